// File: rtl/pipe_pkg.sv
// Shared opcode/funct encodings, the bubble word and small decode helpers
// used by the decode stage and its register file.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic logic is_legal(input instr_t ir);
    logic ok;
    ok = 1'b0;
    case (ir.opcode)
      OP_RTYPE:                 ok = (ir.funct == FN_ADD) || (ir.funct == FN_SUB);
      OP_ADDI, OP_LW, OP_SW:    ok = 1'b1;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only R-type and sw consume rt as a source operand.
  function automatic logic reads_rt(input instr_t ir);
    return (ir.opcode == OP_RTYPE) || (ir.opcode == OP_SW);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two asynchronous read ports, one synchronous write port.
// Write-through read bypass is enabled by defining DECODE_BYPASS_EN.
module regfile_2r1w
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rd_addr_1,
  input  logic [4:0]  rd_addr_2,
  output logic [31:0] rd_data_1,
  output logic [31:0] rd_data_2,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [0:31];

  // r0 is never written, so it holds its cleared value of zero forever.
  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        regs[gi] <= 32'h0;
      end else if (wr_en && (wr_addr == 5'(gi)) && (gi != 0)) begin
        regs[gi] <= wr_data;
      end
    end
  end

  logic [31:0] raw_1;
  logic [31:0] raw_2;

  always_comb begin
    raw_1 = (rd_addr_1 == 5'd0) ? 32'h0 : regs[rd_addr_1];
    raw_2 = (rd_addr_2 == 5'd0) ? 32'h0 : regs[rd_addr_2];
  end

`ifdef DECODE_BYPASS_EN
  logic wr_live;
  always_comb begin
    wr_live   = wr_en && (wr_addr != 5'd0);
    rd_data_1 = (wr_live && (wr_addr == rd_addr_1)) ? wr_data : raw_1;
    rd_data_2 = (wr_live && (wr_addr == rd_addr_2)) ? wr_data : raw_2;
  end
`else
  always_comb begin
    rd_data_1 = raw_1;
    rd_data_2 = raw_2;
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage: register file, load-use hazard stall and the
// EX pipeline register. Optional read bypass via DECODE_BYPASS_EN.
module decode_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = PIPE_NOP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_IR,
  input  logic        if_valid,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] ex_IR,
  output logic [31:0] ex_in_1,
  output logic [31:0] ex_in_2,
  output logic [31:0] ex_immediate,
  output logic        ex_valid
);

  instr_t      id_instr;
  instr_t      ex_instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        id_legal;
  logic        load_use;
  logic        issue;

  assign id_instr = instr_t'(if_IR);
  assign ex_instr = instr_t'(ex_IR);

  regfile_2r1w u_rf (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_1 (id_instr.rs),
    .rd_addr_2 (id_instr.rt),
    .rd_data_1 (rs_val),
    .rd_data_2 (rt_val),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // An illegal instruction becomes a bubble anyway, so it never stalls.
  always_comb begin
    id_legal = is_legal(id_instr);
    load_use = ex_valid && (ex_instr.opcode == OP_LW) && (ex_instr.rt != 5'd0) &&
               ((ex_instr.rt == id_instr.rs) ||
                (reads_rt(id_instr) && (ex_instr.rt == id_instr.rt)));
    stall    = if_valid && id_legal && load_use;
    issue    = if_valid && id_legal && !load_use;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_IR        <= NOP_WORD;
      ex_in_1      <= 32'h0;
      ex_in_2      <= 32'h0;
      ex_immediate <= 32'h0;
      ex_valid     <= 1'b0;
    end else if (issue) begin
      ex_IR        <= if_IR;
      ex_in_1      <= rs_val;
      ex_in_2      <= rt_val;
      ex_immediate <= {{16{if_IR[15]}}, if_IR[15:0]};
      ex_valid     <= 1'b1;
    end else begin
      ex_IR        <= NOP_WORD;
      ex_in_1      <= 32'h0;
      ex_in_2      <= 32'h0;
      ex_immediate <= 32'h0;
      ex_valid     <= 1'b0;
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode / register-read stage of the five-stage pipeline. It sits directly upstream of the ALU stage and directly downstream of fetch. It holds the 32×32 register file, which is written from the writeback stage, and it detects load-use hazards, stalling fetch and inserting a bubble. It registers the execute-stage operands: instruction word, two register operands and the sign-extended immediate.

## Interface
- `NOP_WORD`, default 32'h0000_0000: instruction word issued as a bubble.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `if_IR`  in  32: instruction from fetch.
- `if_valid`  in  1: `if_IR` is meaningful this cycle.
- `wb_en`  in  1: register-file write enable from writeback.
- `wb_addr`  in  5: writeback destination register.
- `wb_data`  in  32: writeback data.
- `stall`  out  1: combinational; fetch must hold `if_IR` when 1.
- `ex_IR`  out  32: registered instruction to the ALU stage.
- `ex_in_1`  out  32: registered rs value.
- `ex_in_2`  out  32: registered rt value.
- `ex_immediate`  out  32: registered sign-extended `IR[15:0]`.
- `ex_valid`  out  1: registered; 0 means the EX slot holds a bubble.

## Operation
- Fields: rs=`IR[25:21]`, rt=`IR[20:16]`, imm=`IR[15:0]`, opcode=`IR[31:26]`, funct=`IR[5:0]`.
- Supported instructions:
  - R-type add (000000/100000) and sub (000000/100010): reads rs and rt.
  - addi (001000) and lw (100011): read rs only.
  - sw (101011): reads rs and rt.
- Unsupported opcode or funct: issued as a bubble (`ex_IR`=`NOP_WORD`, `ex_valid`=0). No stall.
- Immediate: always `{{16{imm[15]}}, imm}`, whatever the opcode.
- Register file:
  - r0 reads as 0.
  - Writes with `wb_addr`=0 are discarded.
  - Write occurs on the rising edge when `wb_en`=1.
- Load-use hazard: `stall`=1 when all of the following hold:
  - `ex_valid`=1 and `ex_IR` opcode is lw;
  - `ex_IR[20:16]`≠0;
  - `ex_IR[20:16]` equals rs of `if_IR`, or equals rt of `if_IR` when `if_IR` is R-type or sw;
  - `if_valid`=1.
- On stall:
  - the EX register loads a bubble;
  - `if_IR` is re-decoded next cycle.
  - At most one stall cycle per lw, because the bubble clears the hazard.
- `if_valid`=0: the EX register loads a bubble and `stall`=0.
- ALU-to-ALU forwarding is not handled here; the ALU stage's scoreboard covers it.

## Timing
- Reset (asserted low, asynchronous):
  - `ex_IR`=`NOP_WORD`; `ex_in_1`, `ex_in_2`, `ex_immediate`=0; `ex_valid`=0.
  - All 32 registers cleared to 0.
  - `stall` follows its combinational equation; it is 0 during reset because `ex_valid`=0.
- Latency: one cycle from `if_IR` to `ex_*`.
- Registers update every rising edge; there is no enable input.
- Read and write to the same register in the same cycle: see Configuration.
- Reset deasserted mid-stall: the pending bubble is lost, and the instruction held by fetch is issued on the first active edge.
- Simultaneous stall and writeback: the write always completes; only the EX register load is affected.

## Configuration
- `DECODE_BYPASS_EN` defined: write-through bypass. When `wb_en`=1, `wb_addr`≠0 and `wb_addr` equals rs (or rt), that operand takes `wb_data` in the same cycle.
- `DECODE_BYPASS_EN` undefined: operands read the pre-write value, and the write becomes visible one cycle later. The compiler or testbench must then separate dependent instructions by one extra slot.

## Structure
- Package `pipe_pkg`:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW;
  - funct constants: FN_ADD, FN_SUB;
  - the NOP word.
- Sub-module `regfile_2r1w`:
  - 32×32 array, two asynchronous read ports, one synchronous write port;
  - r0 hardwired to zero;
  - asynchronous active-low clear;
  - bypass logic selected by `DECODE_BYPASS_EN`.
- Hazard detection and the EX pipeline register live in `decode_stage`.

## Test plan
- Reset: hold `reset`=0 with random inputs → `ex_IR`=0, `ex_valid`=0, all operands 0. After release, decoding add r4,r1,r2 gives `ex_in_1`=`ex_in_2`=0.
- Writeback then read: write r3=0x0000_0010, then decode add r4,r3,r3 (0x0063_2020) → next cycle `ex_in_1`=`ex_in_2`=0x10, `ex_valid`=1.
- Sign extension: addi r1,r0,0xFFFF → `ex_immediate`=0xFFFF_FFFF and `ex_in_1`=0. addi with imm 0x7FFF → 0x0000_7FFF.
- Load-use:
  - lw r2,0(r1) issued, then add r5,r2,r1 presented → `stall`=1 for exactly one cycle, `ex_valid`=0 for that cycle, then the add issues.
  - Repeat with addi r5,r1,7 after the lw → no stall (rt not a source).
- Bypass: in the same cycle, `wb_en`=1, `wb_addr`=7, `wb_data`=0xAA and decode sub r8,r7,r0:
  - `ex_in_1`=0xAA with `DECODE_BYPASS_EN` defined;
  - old r7 value without it.
- r0 and illegal op:
  - writeback to r0 with 0xFFFF_FFFF, then read r0 → 0;
  - opcode 000010 → bubble, `stall`=0.
